// File: rtl/cache_valid_array_if.sv
// cache_valid_array_if
//   Groups every non-clock signal of the cache valid/dirty/tag array into one
//   bundle: the controller lookup and fill/invalidate path, the flush control,
//   and the writeback handshake.
//   slave  : the array itself (cache_valid_array).
//   master : the controller or writeback agent that drives the array.
//   Ports:
//     rd_line/rd_tag              lookup index and tag to compare
//     rd_valid/rd_dirty/rd_tag_out/hit  lookup results (combinational)
//     wr/wr_line/wr_tag/wr_dirty  fill or update strobe and its payload
//     inv                         invalidate wr_line
//     flush_req/flush_busy/flush_done   flush start, activity, completion
//     wb_req/wb_line/wb_tag/wb_ack      writeback handshake for dirty lines
interface cache_valid_array_if #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
);
  logic [IDX_W-1:0] rd_line;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid;
  logic             rd_dirty;
  logic [TAG_W-1:0] rd_tag_out;
  logic             hit;
  logic             wr;
  logic [IDX_W-1:0] wr_line;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_dirty;
  logic             inv;
  logic             flush_req;
  logic             flush_busy;
  logic             flush_done;
  logic             wb_req;
  logic [IDX_W-1:0] wb_line;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_ack;

  modport slave (
    input  rd_line, rd_tag, wr, wr_line, wr_tag, wr_dirty, inv, flush_req, wb_ack,
    output rd_valid, rd_dirty, rd_tag_out, hit, flush_busy, flush_done,
           wb_req, wb_line, wb_tag
  );

  modport master (
    output rd_line, rd_tag, wr, wr_line, wr_tag, wr_dirty, inv, flush_req, wb_ack,
    input  rd_valid, rd_dirty, rd_tag_out, hit, flush_busy, flush_done,
           wb_req, wb_line, wb_tag
  );
endinterface

// File: rtl/cache_valid_array.sv
// cache_valid_array
//   Valid/dirty/tag state for a direct-mapped cache of LINES entries, with a
//   combinational lookup/hit path, fill and invalidate updates, and a flush
//   engine that walks every line, hands dirty lines to a writeback agent over
//   a req/ack handshake, and leaves the array empty.
//   Ports:
//     clk    rising-edge clock for all state
//     reset  asynchronous, active-low reset
//     bus    cache_valid_array_if.slave (lookup, update, flush, writeback)
module cache_valid_array #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  cache_valid_array_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    WB_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags [LINES];

  logic             flush_busy_r;
  logic             flush_done_r;
  logic             wb_req_r;
  logic [IDX_W-1:0] wb_line_r;
  logic [TAG_W-1:0] wb_tag_r;

  logic             last_line;

  // Lookup path reads the registered array directly, so a fill becomes
  // visible only after the edge that performs it.
  assign bus.rd_valid   = valid[bus.rd_line];
  assign bus.rd_dirty   = dirty[bus.rd_line];
  assign bus.rd_tag_out = tags[bus.rd_line];
  assign bus.hit        = valid[bus.rd_line] && (tags[bus.rd_line] == bus.rd_tag);

  assign bus.flush_busy = flush_busy_r;
  assign bus.flush_done = flush_done_r;
  assign bus.wb_req     = wb_req_r;
  assign bus.wb_line    = wb_line_r;
  assign bus.wb_tag     = wb_tag_r;

  assign last_line = (ptr == IDX_W'(LINES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid        <= '0;
      dirty        <= '0;
      for (int i = 0; i < LINES; i++) tags[i] <= '0;
      state        <= IDLE;
      ptr          <= '0;
      flush_busy_r <= 1'b0;
      flush_done_r <= 1'b0;
      wb_req_r     <= 1'b0;
      wb_line_r    <= '0;
      wb_tag_r     <= '0;
    end else begin
      flush_done_r <= 1'b0;
      case (state)
        IDLE: begin
          // Invalidate takes priority over a simultaneous fill.
          if (bus.inv) begin
            valid[bus.wr_line] <= 1'b0;
            dirty[bus.wr_line] <= 1'b0;
          end else if (bus.wr) begin
            valid[bus.wr_line] <= 1'b1;
            dirty[bus.wr_line] <= bus.wr_dirty;
            tags[bus.wr_line]  <= bus.wr_tag;
          end
          if (bus.flush_req) begin
            state        <= SCAN;
            ptr          <= '0;
            flush_busy_r <= 1'b1;
          end
        end

        SCAN: begin
          if (valid[ptr] && dirty[ptr]) begin
            wb_req_r  <= 1'b1;
            wb_line_r <= ptr;
            wb_tag_r  <= tags[ptr];
            state     <= WB_WAIT;
          end else begin
            valid[ptr] <= 1'b0;
            dirty[ptr] <= 1'b0;
            // busy drops in the same cycle the done pulse is presented
            if (last_line) begin
              state        <= DONE;
              flush_busy_r <= 1'b0;
              flush_done_r <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end

        WB_WAIT: begin
          if (bus.wb_ack) begin
            valid[ptr] <= 1'b0;
            dirty[ptr] <= 1'b0;
            wb_req_r   <= 1'b0;
            if (last_line) begin
              state        <= DONE;
              flush_busy_r <= 1'b0;
              flush_done_r <= 1'b1;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= SCAN;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_valid_array.sv
// tb_cache_valid_array
//   Directed bench for cache_valid_array: lookup after reset, fill/hit/miss,
//   fill-vs-invalidate priority, clean flush timing, dirty-line writeback
//   ordering via an expected-writeback queue, and reset during writeback.
module tb_cache_valid_array;

  localparam int LINES = 16;
  localparam int IDX_W = 4;
  localparam int TAG_W = 8;

  typedef struct packed {
    logic [IDX_W-1:0] line;
    logic [TAG_W-1:0] tag;
  } wb_t;

  logic clk;
  logic reset;

  cache_valid_array_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

  cache_valid_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit         m_valid [LINES];
  bit         m_dirty [LINES];
  logic [7:0] m_tag   [LINES];

  wb_t exp_q [$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 8'h00;
    end
  endtask

  task automatic model_empty();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic check_line(input int l, input logic [7:0] t);
    @(negedge clk);
    bus.rd_line = IDX_W'(l);
    bus.rd_tag  = t;
    #1;
    chk($sformatf("rd_valid[%0d]", l),   32'(bus.rd_valid),   32'(m_valid[l]));
    chk($sformatf("rd_dirty[%0d]", l),   32'(bus.rd_dirty),   32'(m_dirty[l]));
    chk($sformatf("rd_tag_out[%0d]", l), 32'(bus.rd_tag_out), 32'(m_tag[l]));
    chk($sformatf("hit[%0d]", l),        32'(bus.hit),
        32'(m_valid[l] && (m_tag[l] == t)));
  endtask

  task automatic do_wr(input int l, input logic [7:0] t, input bit d);
    @(negedge clk);
    bus.wr       = 1'b1;
    bus.wr_line  = IDX_W'(l);
    bus.wr_tag   = t;
    bus.wr_dirty = d;
    @(posedge clk);
    #1;
    bus.wr     = 1'b0;
    m_valid[l] = 1'b1;
    m_dirty[l] = d;
    m_tag[l]   = t;
  endtask

  task automatic do_inv(input int l);
    @(negedge clk);
    bus.inv     = 1'b1;
    bus.wr_line = IDX_W'(l);
    @(posedge clk);
    #1;
    bus.inv    = 1'b0;
    m_valid[l] = 1'b0;
    m_dirty[l] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   busy_cnt;
    int   done_cnt;
    int   done_cyc;
    int   req_cnt;
    int   eps;
    int   waitc;
    bit   in_ep;
    bit   done_seen;
    bit   seen;
    wb_t  cur;

    reset         = 1'b0;
    bus.rd_line   = '0;
    bus.rd_tag    = '0;
    bus.wr        = 1'b0;
    bus.wr_line   = '0;
    bus.wr_tag    = '0;
    bus.wr_dirty  = 1'b0;
    bus.inv       = 1'b0;
    bus.flush_req = 1'b0;
    bus.wb_ack    = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_flush_busy", 32'(bus.flush_busy), 32'(0));
    chk("rst_flush_done", 32'(bus.flush_done), 32'(0));
    chk("rst_wb_req",     32'(bus.wb_req),     32'(0));
    chk("rst_wb_line",    32'(bus.wb_line),    32'(0));
    chk("rst_wb_tag",     32'(bus.wb_tag),     32'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int l = 0; l < LINES; l++) check_line(l, 8'h00);

    // Fill line 5; the result must not appear before the edge.
    @(negedge clk);
    bus.wr       = 1'b1;
    bus.wr_line  = 4'd5;
    bus.wr_tag   = 8'h3A;
    bus.wr_dirty = 1'b0;
    bus.rd_line  = 4'd5;
    bus.rd_tag   = 8'h3A;
    #1;
    chk("no_bypass_valid", 32'(bus.rd_valid), 32'(0));
    chk("no_bypass_hit",   32'(bus.hit),      32'(0));
    @(posedge clk);
    #1;
    bus.wr     = 1'b0;
    m_valid[5] = 1'b1;
    m_dirty[5] = 1'b0;
    m_tag[5]   = 8'h3A;
    check_line(5, 8'h3A);
    check_line(5, 8'h3B);

    // Fill and invalidate together: invalidate wins.
    @(negedge clk);
    bus.wr       = 1'b1;
    bus.inv      = 1'b1;
    bus.wr_line  = 4'd7;
    bus.wr_tag   = 8'h99;
    bus.wr_dirty = 1'b1;
    @(posedge clk);
    #1;
    bus.wr  = 1'b0;
    bus.inv = 1'b0;
    check_line(7, 8'h99);

    // Fill then invalidate: tag survives.
    do_wr(2, 8'h55, 1'b1);
    check_line(2, 8'h55);
    do_inv(2);
    check_line(2, 8'h55);

    // Clean flush; a fill attempted while busy must be ignored.
    @(negedge clk);
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    req_cnt  = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (bus.flush_busy) busy_cnt++;
      if (bus.flush_done) begin
        done_cnt++;
        done_cyc = k;
      end
      if (bus.wb_req) req_cnt++;
      if (k == 3) begin
        bus.wr       = 1'b1;
        bus.wr_line  = 4'd9;
        bus.wr_tag   = 8'h77;
        bus.wr_dirty = 1'b1;
      end
      if (k == 4) bus.wr = 1'b0;
    end
    chk("clean_busy_cycles", 32'(busy_cnt), 32'(16));
    chk("clean_done_count",  32'(done_cnt), 32'(1));
    chk("clean_done_cycle",  32'(done_cyc), 32'(17));
    chk("clean_wb_req_cnt",  32'(req_cnt),  32'(0));
    @(negedge clk);
    chk("clean_after_done",  32'(bus.flush_done), 32'(0));
    chk("clean_after_busy",  32'(bus.flush_busy), 32'(0));
    model_empty();
    for (int l = 0; l < LINES; l++) check_line(l, m_tag[l]);

    // Dirty flush: lines 3 and 12 dirty, line 6 valid but clean.
    do_wr(3,  8'h11, 1'b1);
    do_wr(12, 8'h22, 1'b1);
    do_wr(6,  8'h33, 1'b0);
    exp_q.push_back('{line: 4'd3,  tag: 8'h11});
    exp_q.push_back('{line: 4'd12, tag: 8'h22});
    @(negedge clk);
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    in_ep     = 1'b0;
    done_seen = 1'b0;
    eps       = 0;
    waitc     = 0;
    cur       = '0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      @(negedge clk);
      if (bus.flush_done) begin
        done_seen = 1'b1;
        chk("dirty_busy_at_done", 32'(bus.flush_busy), 32'(0));
      end
      if (bus.wb_ack) begin
        bus.wb_ack = 1'b0;
        in_ep      = 1'b0;
        chk("wb_req_drop", 32'(bus.wb_req), 32'(0));
      end else if (bus.wb_req) begin
        if (!in_ep) begin
          eps++;
          in_ep = 1'b1;
          waitc = 0;
          if (exp_q.size() == 0) begin
            chk("wb_unexpected", 32'(1), 32'(0));
            cur = '{line: bus.wb_line, tag: bus.wb_tag};
          end else begin
            cur = exp_q.pop_front();
            chk("wb_line", 32'(bus.wb_line), 32'(cur.line));
            chk("wb_tag",  32'(bus.wb_tag),  32'(cur.tag));
          end
        end else begin
          waitc++;
          chk("wb_hold_line", 32'(bus.wb_line), 32'(cur.line));
          chk("wb_hold_tag",  32'(bus.wb_tag),  32'(cur.tag));
          if (waitc == 3) bus.wb_ack = 1'b1;
        end
      end
    end
    chk("dirty_done_seen", 32'(done_seen),    32'(1));
    chk("dirty_episodes",  32'(eps),          32'(2));
    chk("dirty_queue_left", 32'(exp_q.size()), 32'(0));
    @(posedge clk);
    #1;
    model_empty();
    for (int l = 0; l < LINES; l++) check_line(l, m_tag[l]);

    // Reset while waiting for the writeback ack on line 3.
    do_wr(3, 8'h11, 1'b1);
    do_wr(8, 8'h44, 1'b1);
    @(negedge clk);
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.wb_req) seen = 1'b1;
    end
    chk("rstwb_req_seen", 32'(seen),        32'(1));
    chk("rstwb_line",     32'(bus.wb_line), 32'(3));
    #2;
    reset = 1'b0;
    #1;
    chk("rstwb_req_drop",  32'(bus.wb_req),     32'(0));
    chk("rstwb_busy_drop", 32'(bus.flush_busy), 32'(0));
    chk("rstwb_done",      32'(bus.flush_done), 32'(0));
    model_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.flush_done) done_cnt++;
      if (bus.flush_busy) busy_cnt++;
    end
    chk("rstwb_no_done", 32'(done_cnt), 32'(0));
    chk("rstwb_no_busy", 32'(busy_cnt), 32'(0));
    for (int l = 0; l < LINES; l++) check_line(l, 8'h11);
    do_wr(4, 8'h5C, 1'b1);
    check_line(4, 8'h5C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
